// File: rtl/fg_pkg.sv
// fg_pkg: field-state type, shadow limits and reset defaults shared by fg_ctrl
package fg_pkg;
  typedef enum logic [1:0] {WAVE = 2'd0, FREQ = 2'd1, AMP = 2'd2} field_t;
  localparam logic [2:0] WAVE_MAX = 3'd4;
  localparam logic [4:0] FREQ_MAX = 5'd31;
  localparam logic [2:0] AMP_MAX = 3'd7;
  localparam logic [2:0] WAVE_RST = 3'd0;
  localparam logic [4:0] FREQ_RST = 5'd8;
  localparam logic [2:0] AMP_RST = 3'd7;
endpackage

// File: rtl/fg_debounce.sv
// fg_debounce: 2-FF sync, debounce and press pulse; FG_CTRL_AUTOREPEAT_EN adds repeats when REP_CNT > 0
module fg_debounce #(
  parameter int DEB_CNT = 1000000,
  parameter int REP_CNT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ev
);
  localparam int CW = $clog2(DEB_CNT + 1);
  if (DEB_CNT < 1 || REP_CNT < 0) $error("fg_debounce: bad DEB_CNT/REP_CNT");
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic lvl, press, done;
  always_comb done = sync[1] != lvl && cnt == CW'(DEB_CNT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      lvl <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == lvl || done) ? '0 : cnt + 1'b1;
      lvl <= done ? sync[1] : lvl;
      press <= done && sync[1];
    end
`ifdef FG_CTRL_AUTOREPEAT_EN
  if (REP_CNT > 0) begin : g_rep
    localparam int RW = $clog2(REP_CNT + 1);
    logic [RW-1:0] rcnt;
    logic rep;
    always_ff @(posedge clk)
      if (rst) begin
        rcnt <= '0;
        rep <= 1'b0;
      end else begin
        rcnt <= (!lvl || rcnt == RW'(REP_CNT - 1)) ? '0 : rcnt + 1'b1;
        rep <= lvl && rcnt == RW'(REP_CNT - 1);
      end
    assign ev = press | rep;
  end else begin : g_norep
    assign ev = press;
  end
`else
  assign ev = press;
`endif
endmodule

// File: rtl/fg_ctrl.sv
// fg_ctrl: button-driven waveform/frequency/amplitude editor; FG_CTRL_AUTOREPEAT_EN enables up/down auto-repeat
module fg_ctrl
  import fg_pkg::*;
#(
  parameter int DEB_CNT = 1000000,
  parameter int REP_CNT = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bto,
  output logic [2:0] func_cnt,
  output logic [4:0] freq_idx,
  output logic [2:0] amp_idx,
  output logic [1:0] edit_field,
  output logic       cfg_upd
);
  logic [3:0] ev;
  field_t field;
  logic [2:0] wave_sh, amp_sh;
  logic [4:0] freq_sh;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    fg_debounce #(.DEB_CNT(DEB_CNT), .REP_CNT(i < 2 ? REP_CNT : 0)) u_deb (
      .clk(clk),
      .rst(rst),
      .raw(bto[i]),
      .ev(ev[i])
    );
  end
  always_comb edit_field = field;
  always_ff @(posedge clk)
    if (rst) begin
      field <= WAVE;
      wave_sh <= WAVE_RST;
      freq_sh <= FREQ_RST;
      amp_sh <= AMP_RST;
      func_cnt <= WAVE_RST;
      freq_idx <= FREQ_RST;
      amp_idx <= AMP_RST;
      cfg_upd <= 1'b0;
    end else begin
      cfg_upd <= ev[3];
      if (ev[3]) begin
        func_cnt <= wave_sh;
        freq_idx <= freq_sh;
        amp_idx <= amp_sh;
      end else if (ev[2]) begin
        field <= field == WAVE ? FREQ : field == FREQ ? AMP : WAVE;
      end else if (ev[0] ^ ev[1]) begin
        if (field == WAVE)
          wave_sh <= ev[0] ? (wave_sh == WAVE_MAX ? 3'd0 : wave_sh + 3'd1)
                           : (wave_sh == 3'd0 ? WAVE_MAX : wave_sh - 3'd1);
        if (field == FREQ)
          freq_sh <= ev[0] ? (freq_sh == FREQ_MAX ? FREQ_MAX : freq_sh + 5'd1)
                           : (freq_sh == 5'd0 ? 5'd0 : freq_sh - 5'd1);
        if (field == AMP)
          amp_sh <= ev[0] ? (amp_sh == AMP_MAX ? AMP_MAX : amp_sh + 3'd1)
                          : (amp_sh == 3'd0 ? 3'd0 : amp_sh - 3'd1);
      end
    end
endmodule

// File: tb/tb_fg_ctrl.sv
// tb_fg_ctrl: directed stimulus, per-cycle compare against a behavioural model, plus literal checks
`timescale 1ns/1ps
module tb_fg_ctrl;
  localparam int DEB = 4;
  localparam int REP = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] bto = 4'b0;
  logic [2:0] func_cnt;
  logic [4:0] freq_idx;
  logic [2:0] amp_idx;
  logic [1:0] edit_field;
  logic cfg_upd;
  int checks = 0;
  int errors = 0;
  int cfg_n = 0;
  int n0;
  fg_ctrl #(.DEB_CNT(DEB), .REP_CNT(REP)) dut (
    .clk(clk),
    .rst(rst),
    .bto(bto),
    .func_cnt(func_cnt),
    .freq_idx(freq_idx),
    .amp_idx(amp_idx),
    .edit_field(edit_field),
    .cfg_upd(cfg_upd)
  );
  always #5 clk = ~clk;

  int m_func, m_freq, m_amp, m_field, m_cfg;
  int m_sh[3];
  int streak[4], age[4];
  bit [3:0] d1, d2, lvl, prev, pend;

  function automatic int clamp(input int v, input int hi);
    return v < 0 ? 0 : v > hi ? hi : v;
  endfunction

  task automatic model_edge(input bit r, input logic [3:0] b);
    bit [3:0] nev;
    int d;
    bit s;
    if (r) begin
      m_func = 0; m_freq = 8; m_amp = 7; m_field = 0; m_cfg = 0;
      m_sh[0] = 0; m_sh[1] = 8; m_sh[2] = 7;
      d1 = '0; d2 = '0; lvl = '0; prev = '0; pend = '0;
      for (int i = 0; i < 4; i++) begin streak[i] = 0; age[i] = 0; end
      return;
    end
    m_cfg = 0;
    if (pend[3]) begin
      m_cfg = 1; m_func = m_sh[0]; m_freq = m_sh[1]; m_amp = m_sh[2];
    end else if (pend[2]) begin
      m_field = (m_field + 1) % 3;
    end else if (pend[0] != pend[1]) begin
      d = pend[0] ? 1 : -1;
      if (m_field == 0) m_sh[0] = (m_sh[0] + d + 5) % 5;
      else if (m_field == 1) m_sh[1] = clamp(m_sh[1] + d, 31);
      else m_sh[2] = clamp(m_sh[2] + d, 7);
    end
    nev = '0;
    for (int i = 0; i < 4; i++) begin
      s = d2[i];
      streak[i] = (s == prev[i]) ? streak[i] + 1 : 1;
      prev[i] = s;
      age[i] = lvl[i] ? age[i] + 1 : 0;
      if (age[i] == REP) begin
        age[i] = 0;
`ifdef FG_CTRL_AUTOREPEAT_EN
        if (i < 2) nev[i] = 1'b1;
`endif
      end
      if (streak[i] >= DEB && s != lvl[i]) begin
        lvl[i] = s;
        if (s) nev[i] = 1'b1;
      end
    end
    d2 = d1;
    d1 = b;
    pend = nev;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge(rst, bto);
    @(negedge clk);
    checks++;
    if (int'(func_cnt) != m_func || int'(freq_idx) != m_freq || int'(amp_idx) != m_amp ||
        int'(edit_field) != m_field || int'(cfg_upd) != m_cfg) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: got func=%0d freq=%0d amp=%0d field=%0d cfg=%0d, expected func=%0d freq=%0d amp=%0d field=%0d cfg=%0d",
               $time, func_cnt, freq_idx, amp_idx, edit_field, cfg_upd, m_func, m_freq, m_amp, m_field, m_cfg);
    end
    if (cfg_upd === 1'b1) cfg_n++;
  end

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input int n = 1);
    repeat (n) begin
      bto = bto | m;
      cyc(8);
      bto = bto & ~m;
      cyc(10);
    end
  endtask

  initial begin
    cyc(3);
    lit("rst_func", func_cnt, 0);
    lit("rst_freq", freq_idx, 8);
    lit("rst_amp", amp_idx, 7);
    lit("rst_field", edit_field, 0);
    lit("rst_cfg", cfg_upd, 0);
    rst = 1'b0;
    cyc(2);
    n0 = cfg_n;
    bto[3] = 1'b1;
    cyc(10);
    bto[3] = 1'b0;
    cyc(10);
    lit("apply_pulses", cfg_n - n0, 1);
    lit("apply_func", func_cnt, 0);
    lit("apply_freq", freq_idx, 8);
    lit("apply_amp", amp_idx, 7);
    bto[0] = 1'b1; cyc(2);
    bto[0] = 1'b0; cyc(1);
    bto[0] = 1'b1; cyc(10);
    bto[0] = 1'b0; cyc(10);
    press(4'b1000);
    lit("bounce_one_up", func_cnt, 1);
    press(4'b0010);
    press(4'b0001, 5);
    press(4'b1000);
    lit("wave_wrap_up", func_cnt, 0);
    press(4'b0010);
    press(4'b1000);
    lit("wave_wrap_down", func_cnt, 4);
    press(4'b0100);
    lit("field_freq", edit_field, 1);
    press(4'b0001, 30);
    press(4'b1000);
    lit("freq_sat", freq_idx, 31);
    lit("freq_amp_kept", amp_idx, 7);
    press(4'b0100);
    lit("field_amp", edit_field, 2);
    press(4'b0100);
    lit("field_wrap", edit_field, 0);
    n0 = cfg_n;
    press(4'b1001);
    lit("apply_beats_up", func_cnt, 4);
    lit("apply_beats_up_pulse", cfg_n - n0, 1);
    press(4'b0001);
    press(4'b1000);
    lit("shadow_kept", func_cnt, 0);
    press(4'b0011);
    press(4'b1000);
    lit("up_down_cancel", func_cnt, 0);
    press(4'b0100, 2);
    press(4'b0010, 7);
    bto[0] = 1'b1;
    cyc(60);
    bto[0] = 1'b0;
    cyc(10);
    press(4'b1000);
`ifdef FG_CTRL_AUTOREPEAT_EN
    lit("amp_hold", amp_idx, 4);
`else
    lit("amp_hold", amp_idx, 1);
`endif
    bto[2] = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    bto[2] = 1'b0;
    cyc(10);
    lit("held_thru_rst_field", edit_field, 1);
    lit("held_thru_rst_amp", amp_idx, 7);
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fg_ctrl.md
FG_CTRL -- requirements
Module: fg_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 1000000, number of consecutive stable-high synchronized samples before a button counts as pressed.
REQ-002 Parameter REP_CNT, default 25000000, hold time in cycles between auto-repeat steps (used only with FG_CTRL_AUTOREPEAT_EN).
REQ-003 One clock; reset is synchronous and active-high; ports are clk and rst.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bto  input  4  raw asynchronous buttons: [0] up, [1] down, [2] next field, [3] apply.
REQ-007 func_cnt  output  3  committed waveform select, 0..4.
REQ-008 freq_idx  output  5  committed frequency step index, 0..31.
REQ-009 amp_idx  output  3  committed amplitude index, 0..7.
REQ-010 edit_field  output  2  field being edited: 0 WAVE, 1 FREQ, 2 AMP; 3 is never driven.
REQ-011 cfg_upd  output  1  one-cycle pulse when committed outputs change through apply.

Function
REQ-012 Each bto bit SHALL pass a 2-FF synchronizer and then a debouncer; the debounced level rises after DEB_CNT consecutive high synchronized samples and falls after DEB_CNT consecutive low samples.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced rising edge; holding or releasing a button generates no other events unless auto-repeat is enabled.
REQ-014 Any low sample before the count completes SHALL restart the debounce count; glitches shorter than DEB_CNT cycles SHALL produce no event.
REQ-015 The field FSM has states WAVE, FREQ, AMP; a next-field event moves WAVE->FREQ->AMP->WAVE; edit_field reflects the new state one cycle after the event.
REQ-016 Up/down events SHALL edit only the shadow register of the current field, never the committed outputs.
REQ-017 WAVE shadow: up wraps 4->0; down wraps 0->4.
REQ-018 FREQ shadow: saturates at 31 on up and at 0 on down; AMP shadow saturates at 7 and 0.
REQ-019 An apply event SHALL copy all three shadows to func_cnt/freq_idx/amp_idx and assert cfg_upd for exactly one cycle, both visible one cycle after the event.
REQ-020 Apply with shadows equal to the committed values SHALL still pulse cfg_upd.
REQ-021 Simultaneous events priority: apply > next-field > up/down; lower-priority events in that cycle are dropped.
REQ-022 Up and down in the same cycle SHALL cancel, leaving the shadow unchanged.
REQ-023 Apply and an edit in the same cycle SHALL commit the pre-edit shadow; the edit is dropped.

Reset
REQ-024 On rst, func_cnt and WAVE shadow = 0, freq_idx and FREQ shadow = 8, amp_idx and AMP shadow = 7, edit_field = WAVE, cfg_upd = 0.
REQ-025 On rst, synchronizers, debounce counters and debounced levels = 0; a button held through reset SHALL need a full DEB_CNT after reset release before it generates an event.
REQ-026 rst asserted mid-debounce or mid-repeat SHALL discard the partial count and emit no event.

Configuration
REQ-027 With FG_CTRL_AUTOREPEAT_EN defined, a debounced up or down held for REP_CNT cycles after its press event SHALL emit a further event, and one more every REP_CNT cycles while held.
REQ-028 Auto-repeat SHALL obey the wrap and saturation rules and stop on release; next-field and apply never repeat.
REQ-029 Without FG_CTRL_AUTOREPEAT_EN, no repeat logic SHALL exist and only press events occur.

Structure
REQ-030 Shared package fg_pkg SHALL hold the field-state typedef, the WAVE_MAX=4, FREQ_MAX=31 and AMP_MAX=7 constants, and the reset defaults 0/8/7.
REQ-031 Synchronizer, debouncer and edge detection SHALL be sub-module fg_debounce, instantiated four times; the FSM, shadows and commit stay in fg_ctrl.

Verification (DEB_CNT=4, REP_CNT=16)
REQ-032 Reset, then bto[3] high for 10 cycles -> cfg_upd pulses once; func_cnt=0, freq_idx=8, amp_idx=7.
REQ-033 Bounce bto[0] high for 2 cycles, low for 1, then hold high -> exactly one up event, counted from the final rise.
REQ-034 In WAVE, five up presses then apply -> func_cnt=0 (wrap); one down press then apply -> func_cnt=4.
REQ-035 Next-field to FREQ, 30 up presses, apply -> freq_idx=31; next-field twice -> edit_field=0 (WAVE).
REQ-036 bto[0] and bto[3] debounced on the same cycle -> committed values are the pre-edit shadows and the shadow is unchanged; bto[0] and bto[1] together -> no change.
REQ-037 With FG_CTRL_AUTOREPEAT_EN, in AMP from 0, hold up for 60 cycles after the press event -> 1+3 events, amp_idx=4 after apply; without the macro -> amp_idx=1.
